// File: rtl/store_datapath_if.sv
`default_nettype none
// ============================================================================
// Module      : store_datapath_if
// Description : Stream/handshake bundle for the SHAKE squeeze stage. The
//               master modport is the store_datapath side, which takes rate
//               blocks in and drives the word stream out. The slave modport
//               is the surrounding core/sink. Optional data_out_keep is
//               present when STORE_KEEP_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface store_datapath_if #(
    parameter int W        = 64,
    parameter int RATE_MAX = 1344,
    parameter int SIZE_W   = 32
);
    logic                start;
    logic [1:0]          operation_mode;
    logic [SIZE_W-1:0]   output_size;
    logic                block_valid;
    logic                block_ready;
    logic [RATE_MAX-1:0] state_in;
    logic                squeeze_request;
    logic [W-1:0]        data_out;
    logic                data_out_valid;
    logic                data_out_ready;
    logic                last_output_word;
    logic                busy;
    logic                done;
`ifdef STORE_KEEP_EN
    logic [W/8-1:0]      data_out_keep;
`endif

    modport master (
`ifdef STORE_KEEP_EN
        output data_out_keep,
`endif
        input  start, operation_mode, output_size, block_valid, state_in, data_out_ready,
        output block_ready, squeeze_request, data_out, data_out_valid, last_output_word,
        output busy, done
    );

    modport slave (
`ifdef STORE_KEEP_EN
        input  data_out_keep,
`endif
        output start, operation_mode, output_size, block_valid, state_in, data_out_ready,
        input  block_ready, squeeze_request, data_out, data_out_valid, last_output_word,
        input  busy, done
    );
endinterface
`default_nettype wire

// File: rtl/store_datapath.sv
`default_nettype none
// ============================================================================
// Module      : store_datapath
// Description : SHAKE squeeze stage. Accepts permuted rate blocks, shifts
//               them out LSB first as W-bit words on a valid/ready stream,
//               counts down the requested bit length and asks the core for
//               another permutation when a block runs dry. The final word is
//               zero-padded above the remaining bit count.
//               Define STORE_KEEP_EN to add the data_out_keep byte enables.
// Revision    : 1.0 - initial release
// ============================================================================
module store_datapath #(
    parameter int         W                 = 64,
    parameter int         RATE_MAX          = 1344,
    parameter int         SIZE_W            = 32,
    parameter logic [1:0] SHAKE128_MODE_VEC = 2'b00,
    parameter logic [1:0] SHAKE256_MODE_VEC = 2'b01
) (
    input  wire logic         clk,
    input  wire logic         rst,     // asynchronous, active low
    store_datapath_if.master  bus
);
    localparam int c_RATE_256  = 1088;
    localparam int c_DEPTH_128 = RATE_MAX / W;
    localparam int c_DEPTH_256 = c_RATE_256 / W;
    localparam int c_WL_W      = $clog2(c_DEPTH_128 + 1);
    localparam int c_KB_W      = $clog2(W + 8);
    localparam int c_KEEP_W    = W / 8;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_BLOCK = 2'd1,
        S_STREAM     = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [RATE_MAX-1:0] r_piso;
    logic [c_WL_W-1:0]   r_words_left;
    logic [SIZE_W-1:0]   r_bits_left;
    logic                r_mode_256;
    logic                r_busy;
    logic                r_done;

    logic                w_mode_ok;
    logic                w_stream;
    logic                w_last;
    logic [c_KB_W-1:0]   w_bits_small;
    logic [W-1:0]        w_mask;
    logic                w_block_ready;
    logic                w_valid;
    logic                w_squeeze;

    assign w_mode_ok    = (bus.operation_mode == SHAKE128_MODE_VEC) ||
                          (bus.operation_mode == SHAKE256_MODE_VEC);
    assign w_stream     = (r_state == S_STREAM);
    // Last word whenever no more than one word's worth of bits remains.
    assign w_last       = w_stream && (r_bits_left <= SIZE_W'(W));
    // Only meaningful on the last word, where bits_left is at most W.
    assign w_bits_small = r_bits_left[c_KB_W-1:0];
    assign w_mask       = w_last ? ({W{1'b1}} >> (c_KB_W'(W) - w_bits_small)) : {W{1'b1}};

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and handshake-side outputs.
    always_comb begin
        w_state_next  = r_state;
        w_block_ready = 1'b0;
        w_valid       = 1'b0;
        w_squeeze     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start && w_mode_ok && (bus.output_size != '0)) begin
                    w_state_next = S_WAIT_BLOCK;
                end
            end
            S_WAIT_BLOCK: begin
                w_block_ready = 1'b1;
                if (bus.block_valid) begin
                    w_state_next = S_STREAM;
                end
            end
            S_STREAM: begin
                w_valid = 1'b1;
                if (bus.data_out_ready) begin
                    if (w_last) begin
                        w_state_next = S_IDLE;
                    end else if (r_words_left == c_WL_W'(1)) begin
                        // Block exhausted but bits remain: fetch another permutation.
                        w_state_next = S_WAIT_BLOCK;
                        w_squeeze    = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Request bookkeeping, PISO shifting and the done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_piso       <= '0;
            r_words_left <= '0;
            r_bits_left  <= '0;
            r_mode_256   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start && w_mode_ok) begin
                        if (bus.output_size == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_busy      <= 1'b1;
                            r_bits_left <= bus.output_size;
                            r_mode_256  <= (bus.operation_mode == SHAKE256_MODE_VEC);
                        end
                    end
                end
                S_WAIT_BLOCK: begin
                    if (bus.block_valid) begin
                        // Bits above the SHAKE256 rate are never shifted out in that mode.
                        r_piso       <= bus.state_in;
                        r_words_left <= r_mode_256 ? c_WL_W'(c_DEPTH_256) : c_WL_W'(c_DEPTH_128);
                    end
                end
                S_STREAM: begin
                    if (bus.data_out_ready) begin
                        r_piso       <= r_piso >> W;
                        r_words_left <= r_words_left - c_WL_W'(1);
                        r_bits_left  <= (r_bits_left > SIZE_W'(W)) ? (r_bits_left - SIZE_W'(W)) : '0;
                        if (w_last) begin
                            r_busy <= 1'b0;
                            r_done <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.block_ready      = w_block_ready;
    assign bus.data_out_valid   = w_valid;
    assign bus.squeeze_request  = w_squeeze;
    assign bus.data_out         = w_stream ? (r_piso[W-1:0] & w_mask) : '0;
    assign bus.last_output_word = w_last;
    assign bus.busy             = r_busy;
    assign bus.done             = r_done;

`ifdef STORE_KEEP_EN
    logic [c_KB_W-1:0] w_nbytes;
    // ceil(bits_left / 8) bytes on the final word.
    assign w_nbytes = (w_bits_small + c_KB_W'(7)) >> 3;
    assign bus.data_out_keep = !w_stream ? '0 :
                               w_last    ? ({c_KEEP_W{1'b1}} >> (c_KB_W'(c_KEEP_W) - w_nbytes)) :
                                           {c_KEEP_W{1'b1}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_store_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_datapath
// Description : Self-checking bench for store_datapath. A request-level
//               model (queue of pending block words plus remaining bit
//               count) predicts every output each cycle; directed cases pin
//               exact word values, padding, squeeze and done timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_datapath;
    localparam int W        = 64;
    localparam int RATE_MAX = 1344;
    localparam int SIZE_W   = 32;
    localparam int KW       = W / 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    store_datapath_if #(.W(W), .RATE_MAX(RATE_MAX), .SIZE_W(SIZE_W)) bus ();

    store_datapath #(.W(W), .RATE_MAX(RATE_MAX), .SIZE_W(SIZE_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit           m_active = 0;
    logic [W-1:0] m_q[$];
    longint       m_bits = 0;
    bit           m_256 = 0;
    bit           m_done = 0;

    logic [W-1:0] cap_d[$];
    bit           cap_l[$];
    logic [KW-1:0] cap_k[$];
    int           done_cnt = 0;
    int           sq_cnt   = 0;

    function automatic logic [W-1:0] lowmask(input longint b);
        logic [W-1:0] ones;
        ones = '1;
        if (b >= W) return ones;
        return ones >> (W - b);
    endfunction

    function automatic logic [KW-1:0] keepmask(input longint b);
        logic [KW-1:0] ones;
        longint nb;
        ones = '1;
        if (b >= W) return ones;
        nb = (b + 7) / 8;
        return ones >> (KW - nb);
    endfunction

    always @(negedge clk) begin
        logic [5:0]    act_st;
        logic [5:0]    exp_st;
        logic [W-1:0]  exp_d;
        logic [KW-1:0] exp_k;
        logic [KW-1:0] act_k;
        bit ev, el, ebr, esq, was_active;
        act_st = {bus.busy, bus.done, bus.block_ready, bus.squeeze_request,
                  bus.data_out_valid, bus.last_output_word};
`ifdef STORE_KEEP_EN
        act_k = bus.data_out_keep;
`else
        act_k = '0;
`endif
        if (!rst) begin
            m_active = 0; m_q.delete(); m_bits = 0; m_done = 0;
            chk("reset_status", W'(act_st), '0);
            chk("reset_data", bus.data_out, '0);
`ifdef STORE_KEEP_EN
            chk("reset_keep", W'(act_k), '0);
`endif
        end else begin
            ev  = m_active && (m_q.size() > 0);
            el  = ev && (m_bits <= W);
            ebr = m_active && (m_q.size() == 0);
            esq = ev && bus.data_out_ready && !el && (m_q.size() == 1);
            exp_d = ev ? (m_q[0] & lowmask(m_bits)) : '0;
            exp_k = ev ? keepmask(m_bits) : '0;
            exp_st = {m_active, m_done, ebr, esq, ev, el};
            chk("status{busy,done,brdy,sq,vld,last}", W'(act_st), W'(exp_st));
            chk("data_out", bus.data_out, exp_d);
`ifdef STORE_KEEP_EN
            chk("keep", W'(act_k), W'(exp_k));
`endif
            if (bus.done) done_cnt++;
            if (bus.squeeze_request) sq_cnt++;
            if (bus.data_out_valid && bus.data_out_ready) begin
                cap_d.push_back(bus.data_out);
                cap_l.push_back(bus.last_output_word);
                cap_k.push_back(act_k);
            end
            // advance the model to the state after the coming rising edge
            was_active = m_active;
            m_done = 0;
            if (ev && bus.data_out_ready) begin
                void'(m_q.pop_front());
                m_bits = (m_bits > W) ? m_bits - W : 0;
                if (el) begin
                    m_active = 0; m_q.delete(); m_done = 1;
                end
            end
            if (ebr && bus.block_valid) begin
                for (int i = 0; i < (m_256 ? 1088 / W : RATE_MAX / W); i++)
                    m_q.push_back(bus.state_in[i*W +: W]);
            end
            if (!was_active && bus.start && (bus.operation_mode == 2'b00 || bus.operation_mode == 2'b01)) begin
                if (bus.output_size == 0) begin
                    m_done = 1;
                end else begin
                    m_active = 1;
                    m_bits   = bus.output_size;
                    m_256    = (bus.operation_mode == 2'b01);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_block(output logic [RATE_MAX-1:0] b);
        for (int i = 0; i < RATE_MAX / 32; i++) b[i*32 +: 32] = $urandom();
    endtask

    task automatic do_start(input logic [1:0] mode, input int size);
        bus.start = 1'b1; bus.operation_mode = mode; bus.output_size = SIZE_W'(size);
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int maxc, input string nm);
        int c = 0;
        while (done_cnt == d0 && c < maxc) begin tick(); c++; end
        chk(nm, W'(c < maxc), W'(1));
    endtask

    task automatic clear_caps();
        cap_d.delete(); cap_l.delete(); cap_k.delete();
    endtask

    logic [RATE_MAX-1:0] blk;
    int d0, s0, c;

    initial begin
        bus.start = 0; bus.operation_mode = 0; bus.output_size = 0;
        bus.block_valid = 0; bus.state_in = '0; bus.data_out_ready = 0;
        repeat (3) tick();
        chk("reset_busy_lit", W'(bus.busy), '0);
        rst = 1'b1;
        tick();

        // SHAKE128, 256 bits, continuous ready
        rand_block(blk); bus.state_in = blk; bus.block_valid = 1; bus.data_out_ready = 1;
        clear_caps(); d0 = done_cnt; s0 = sq_cnt;
        do_start(2'b00, 256);
        wait_done(d0, 50, "t1_timeout");
        chk("t1_count", W'(cap_d.size()), W'(4));
        for (int i = 0; i < 4 && i < cap_d.size(); i++) chk("t1_word", cap_d[i], blk[i*W +: W]);
        if (cap_l.size() == 4) chk("t1_last_flags", W'({cap_l[0], cap_l[1], cap_l[2], cap_l[3]}), W'(4'b0001));
        chk("t1_no_squeeze", W'(sq_cnt - s0), '0);
        tick();

        // SHAKE256, 1152 bits: one full block, squeeze, one word of the next
        rand_block(blk); bus.state_in = blk;
        clear_caps(); d0 = done_cnt; s0 = sq_cnt;
        do_start(2'b01, 1152);
        wait_done(d0, 80, "t2_timeout");
        chk("t2_count", W'(cap_d.size()), W'(18));
        if (cap_d.size() == 18) begin
            chk("t2_word17", cap_d[16], blk[1087:1024]);
            chk("t2_word18", cap_d[17], blk[63:0]);
            chk("t2_last17", W'(cap_l[16]), '0);
            chk("t2_last18", W'(cap_l[17]), W'(1));
        end
        chk("t2_squeezes", W'(sq_cnt - s0), W'(1));
        tick();

        // SHAKE128, 100 bits: partial, zero-padded last word
        rand_block(blk); bus.state_in = blk;
        clear_caps(); d0 = done_cnt;
        do_start(2'b00, 100);
        wait_done(d0, 50, "t3_timeout");
        chk("t3_count", W'(cap_d.size()), W'(2));
        if (cap_d.size() == 2) begin
            chk("t3_word2", cap_d[1], {28'b0, blk[99:64]});
`ifdef STORE_KEEP_EN
            chk("t3_keep2", W'(cap_k[1]), W'(8'h1F));
`endif
        end
        tick();

        // size 0: no stream, done one cycle after start
        clear_caps(); d0 = done_cnt;
        do_start(2'b00, 0);
        tick(); tick();
        chk("t4_done", W'(done_cnt - d0), W'(1));
        chk("t4_no_words", W'(cap_d.size()), '0);

        // reset during word 5 of 21
        rand_block(blk); bus.state_in = blk;
        clear_caps();
        do_start(2'b00, 2 * RATE_MAX);
        c = 0;
        while (cap_d.size() < 4 && c < 50) begin tick(); c++; end
        chk("t6_reach_word5", W'(cap_d.size()), W'(4));
        rst = 1'b0;
        #1;
        chk("t6_async_status", W'({bus.busy, bus.block_ready, bus.data_out_valid, bus.last_output_word}), '0);
        chk("t6_async_data", bus.data_out, '0);
        tick(); tick();
        rst = 1'b1;
        d0 = done_cnt;
        repeat (5) tick();
        chk("t6_no_done", W'(done_cnt - d0), '0);
        clear_caps(); d0 = done_cnt;
        do_start(2'b00, 256);
        wait_done(d0, 50, "t6_restart_timeout");
        chk("t6_restart_count", W'(cap_d.size()), W'(4));
        chk("t6_restart_word1", cap_d.size() > 0 ? cap_d[0] : '0, blk[63:0]);

        // randomized traffic: random ready/valid, starts (incl. invalid modes and while busy)
        for (int k = 0; k < 4000; k++) begin
            bus.data_out_ready = ($urandom_range(0, 3) != 0);
            bus.block_valid    = ($urandom_range(0, 2) != 0);
            rand_block(blk); bus.state_in = blk;
            bus.start          = ($urandom_range(0, 20) == 0);
            bus.operation_mode = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0:       bus.output_size = '0;
                1:       bus.output_size = SIZE_W'(W * $urandom_range(1, 30));
                default: bus.output_size = SIZE_W'($urandom_range(1, 2500));
            endcase
            tick();
        end
        bus.start = 0;
        bus.data_out_ready = 1;
        bus.block_valid = 1;
        c = 0;
        while (m_active && c < 200) begin tick(); c++; end
        chk("drain_timeout", W'(c < 200), W'(1));
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
